// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register in front of the ALU.
// Resolves operand forwarding from EX/MEM/WB at capture time, stalls decode on
// load-use hazards, honours back-pressure and flush, and counts load-use bubbles.
module alu_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_pc,
    input  logic [4:0]  dec_rs1_addr,
    input  logic [4:0]  dec_rs2_addr,
    input  logic [31:0] dec_rs1_data,
    input  logic [31:0] dec_rs2_data,
    input  logic [31:0] dec_imm,
    input  logic [4:0]  dec_rd_addr,
    input  logic        dec_reg_wr,
    input  logic        dec_is_load,
    input  logic        dec_a_sel,
    input  logic        dec_b_sel,
    input  logic [3:0]  dec_alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    input  logic [31:0] alu_result,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_reg_wr,
    output logic        ex_is_load,
    output logic [31:0] ex_store_data,
    input  logic        mem_reg_wr,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_data,
    input  logic        wb_reg_wr,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic [15:0] bubble_cnt
);

    logic        adv;
    logic        load_use;
    logic        capture;
    logic        ex_fwd_ok;
    logic [31:0] fwd_rs1;
    logic [31:0] fwd_rs2;

    // The held instruction can be replaced when it is empty or being consumed;
    // a held load cannot forward because its data is not known until MEM.
    assign adv       = ~ex_valid | ex_ready;
    assign load_use  = ex_valid & ex_is_load & dec_valid & (ex_rd_addr != 5'd0) &
                       ((ex_rd_addr == dec_rs1_addr) | (ex_rd_addr == dec_rs2_addr));
    assign dec_ready = adv & ~load_use & ~flush;
    assign capture   = dec_valid & dec_ready;
    assign ex_fwd_ok = ex_valid & ex_reg_wr & ~ex_is_load;

    // Pick the youngest in-flight producer of rs1; x0 always reads the register file.
    always_comb begin
        fwd_rs1 = dec_rs1_data;
        if (dec_rs1_addr != 5'd0) begin
            if (ex_fwd_ok && (ex_rd_addr == dec_rs1_addr)) begin
                fwd_rs1 = alu_result;
            end else if (mem_reg_wr && (mem_rd_addr == dec_rs1_addr)) begin
                fwd_rs1 = mem_data;
            end else if (wb_reg_wr && (wb_rd_addr == dec_rs1_addr)) begin
                fwd_rs1 = wb_data;
            end
        end
    end

    // Same priority chain for rs2, which also feeds the store data path.
    always_comb begin
        fwd_rs2 = dec_rs2_data;
        if (dec_rs2_addr != 5'd0) begin
            if (ex_fwd_ok && (ex_rd_addr == dec_rs2_addr)) begin
                fwd_rs2 = alu_result;
            end else if (mem_reg_wr && (mem_rd_addr == dec_rs2_addr)) begin
                fwd_rs2 = mem_data;
            end else if (wb_reg_wr && (wb_rd_addr == dec_rs2_addr)) begin
                fwd_rs2 = wb_data;
            end
        end
    end

    // Pipeline register: flush kills, advance captures or bubbles, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            alu_a         <= 32'd0;
            alu_b         <= 32'd0;
            alu_op        <= 4'd0;
            ex_rd_addr    <= 5'd0;
            ex_reg_wr     <= 1'b0;
            ex_is_load    <= 1'b0;
            ex_store_data <= 32'd0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
        end else if (adv) begin
            if (capture) begin
                ex_valid      <= 1'b1;
                alu_a         <= dec_a_sel ? dec_pc : fwd_rs1;
                alu_b         <= dec_b_sel ? dec_imm : fwd_rs2;
                alu_op        <= dec_alu_op;
                ex_rd_addr    <= dec_rd_addr;
                ex_reg_wr     <= dec_reg_wr;
                ex_is_load    <= dec_is_load;
                ex_store_data <= fwd_rs2;
            end else begin
                ex_valid  <= 1'b0;
                ex_reg_wr <= 1'b0;
            end
        end
    end

    // Count cycles where a load-use stall actually injects a bubble, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= 16'd0;
        end else if (load_use && adv && !flush && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for the ID/EX issue stage.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic [31:0] dec_rs1_data;
    logic [31:0] dec_rs2_data;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd_addr;
    logic        dec_reg_wr;
    logic        dec_is_load;
    logic        dec_a_sel;
    logic        dec_b_sel;
    logic [3:0]  dec_alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_result;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_wr;
    logic        ex_is_load;
    logic [31:0] ex_store_data;
    logic        mem_reg_wr;
    logic [4:0]  mem_rd_addr;
    logic [31:0] mem_data;
    logic        wb_reg_wr;
    logic [4:0]  wb_rd_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic [15:0] bubble_cnt;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wr;
        logic        ld;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pc(dec_pc),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
        .dec_imm(dec_imm), .dec_rd_addr(dec_rd_addr), .dec_reg_wr(dec_reg_wr),
        .dec_is_load(dec_is_load), .dec_a_sel(dec_a_sel), .dec_b_sel(dec_b_sel),
        .dec_alu_op(dec_alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr), .ex_is_load(ex_is_load),
        .ex_store_data(ex_store_data), .mem_reg_wr(mem_reg_wr),
        .mem_rd_addr(mem_rd_addr), .mem_data(mem_data), .wb_reg_wr(wb_reg_wr),
        .wb_rd_addr(wb_rd_addr), .wb_data(wb_data), .flush(flush),
        .bubble_cnt(bubble_cnt)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] rs1d, input logic [31:0] rs2d,
                                  input logic [31:0] imm, input logic [4:0] rd,
                                  input logic wr, input logic ld, input logic asel,
                                  input logic bsel, input logic [3:0] op);
        dec_valid    = v;
        dec_pc       = pc;
        dec_rs1_addr = rs1;
        dec_rs2_addr = rs2;
        dec_rs1_data = rs1d;
        dec_rs2_data = rs2d;
        dec_imm      = imm;
        dec_rd_addr  = rd;
        dec_reg_wr   = wr;
        dec_is_load  = ld;
        dec_a_sel    = asel;
        dec_b_sel    = bsel;
        dec_alu_op   = op;
        #1;
    endtask

    task automatic set_bypass(input logic mwr, input logic [4:0] mrd, input logic [31:0] md,
                              input logic wwr, input logic [4:0] wrd, input logic [31:0] wd);
        mem_reg_wr  = mwr;
        mem_rd_addr = mrd;
        mem_data    = md;
        wb_reg_wr   = wwr;
        wb_rd_addr  = wrd;
        wb_data     = wd;
        #1;
    endtask

    task automatic push_expected(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] store, input logic [3:0] op,
                                 input logic [4:0] rd, input logic wr, input logic ld);
        exp_t e;
        e.a = a; e.b = b; e.store = store; e.op = op; e.rd = rd; e.wr = wr; e.ld = ld;
        sb.push_back(e);
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".ex_valid"},      32'(ex_valid),      32'd1);
            check({tag, ".alu_a"},         alu_a,              e.a);
            check({tag, ".alu_b"},         alu_b,              e.b);
            check({tag, ".alu_op"},        32'(alu_op),        32'(e.op));
            check({tag, ".ex_rd_addr"},    32'(ex_rd_addr),    32'(e.rd));
            check({tag, ".ex_reg_wr"},     32'(ex_reg_wr),     32'(e.wr));
            check({tag, ".ex_is_load"},    32'(ex_is_load),    32'(e.ld));
            check({tag, ".ex_store_data"}, ex_store_data,      e.store);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".ex_valid"},      32'(ex_valid),   32'd0);
        check({tag, ".alu_a"},         alu_a,           32'd0);
        check({tag, ".alu_b"},         alu_b,           32'd0);
        check({tag, ".alu_op"},        32'(alu_op),     32'd0);
        check({tag, ".ex_rd_addr"},    32'(ex_rd_addr), 32'd0);
        check({tag, ".ex_reg_wr"},     32'(ex_reg_wr),  32'd0);
        check({tag, ".ex_is_load"},    32'(ex_is_load), 32'd0);
        check({tag, ".ex_store_data"}, ex_store_data,   32'd0);
        check({tag, ".bubble_cnt"},    32'(bubble_cnt), 32'd0);
    endtask

    // Directed sequence covering capture, forwarding, load-use, back-pressure, flush and reset.
    initial begin
        rst_n      = 1'b0;
        ex_ready   = 1'b1;
        flush      = 1'b0;
        alu_result = 32'd0;
        set_bypass(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        apply_stimulus(1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;

        // addi x1,x0,5
        apply_stimulus(1'b1, 32'h0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        check("addi.dec_ready", 32'(dec_ready), 32'd1);
        push_expected(32'd0, 32'd5, 32'd0, 4'd0, 5'd1, 1'b1, 1'b0);
        tick();
        check_output("addi");

        // add x2,x1,x1 with EX beating MEM and WB
        alu_result = 32'd5;
        set_bypass(1'b1, 5'd1, 32'd7, 1'b1, 5'd1, 32'd9);
        apply_stimulus(1'b1, 32'h4, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_expected(32'd5, 32'd5, 32'd5, 4'd0, 5'd2, 1'b1, 1'b0);
        tick();
        check_output("add_ex_fwd");

        // lw x3,0(x2) takes x2 from EX
        alu_result = 32'd10;
        set_bypass(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        apply_stimulus(1'b1, 32'h8, 5'd2, 5'd0, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        push_expected(32'd10, 32'd0, 32'd0, 4'd0, 5'd3, 1'b1, 1'b1);
        tick();
        check_output("lw");

        // sub x4,x3,x0 stalls one cycle then forwards from MEM
        alu_result = 32'd0;
        apply_stimulus(1'b1, 32'hC, 5'd3, 5'd0, 32'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
        check("loaduse.dec_ready", 32'(dec_ready), 32'd0);
        tick();
        check("bubble.ex_valid",   32'(ex_valid),   32'd0);
        check("bubble.ex_reg_wr",  32'(ex_reg_wr),  32'd0);
        check("bubble.bubble_cnt", 32'(bubble_cnt), 32'd1);
        check("bubble.alu_a_hold", alu_a,           32'd10);
        check("bubble.rd_hold",    32'(ex_rd_addr), 32'd3);
        set_bypass(1'b1, 5'd3, 32'h1234, 1'b0, 5'd0, 32'd0);
        check("after_bubble.dec_ready", 32'(dec_ready), 32'd1);
        push_expected(32'h1234, 32'd0, 32'd0, 4'd7, 5'd4, 1'b1, 1'b0);
        tick();
        check_output("sub_mem_fwd");
        check("sub.bubble_cnt", 32'(bubble_cnt), 32'd1);

        // x0 writers everywhere must never forward
        set_bypass(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB);
        apply_stimulus(1'b1, 32'h10, 5'd0, 5'd0, 32'd0, 32'd0, 32'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        push_expected(32'd0, 32'd3, 32'd0, 4'd0, 5'd0, 1'b1, 1'b0);
        tick();
        check_output("addi_x0");
        alu_result = 32'hCCCC;
        apply_stimulus(1'b1, 32'h14, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        push_expected(32'd0, 32'd0, 32'd0, 4'd0, 5'd5, 1'b1, 1'b0);
        tick();
        check_output("add_x0_src");

        // or x6,x7,x8 with x7 from WB and x8 from MEM
        alu_result = 32'd0;
        set_bypass(1'b1, 5'd8, 32'h66, 1'b1, 5'd7, 32'h55);
        apply_stimulus(1'b1, 32'h18, 5'd7, 5'd8, 32'h11, 32'h22, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        push_expected(32'h55, 32'h66, 32'h66, 4'd5, 5'd6, 1'b1, 1'b0);
        tick();
        check_output("or_mem_wb_fwd");

        // Back-pressure for three cycles with a pending pc-relative op using opcode 11
        set_bypass(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        ex_ready = 1'b0;
        apply_stimulus(1'b1, 32'h100, 5'd0, 5'd0, 32'd0, 32'd0, 32'h2000, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 4'd11);
        for (int i = 0; i < 3; i++) begin
            check("stall.dec_ready", 32'(dec_ready), 32'd0);
            tick();
            check("stall.ex_valid", 32'(ex_valid), 32'd1);
            check("stall.alu_a",    alu_a,         32'h55);
            check("stall.alu_op",   32'(alu_op),   32'd5);
        end
        ex_ready = 1'b1;
        #1;
        check("release.dec_ready", 32'(dec_ready), 32'd1);
        push_expected(32'h100, 32'h2000, 32'd0, 4'd11, 5'd9, 1'b1, 1'b0);
        tick();
        check_output("auipc_after_stall");

        // lw x10,4(x1), then flush while a dependent instruction waits
        apply_stimulus(1'b1, 32'h104, 5'd1, 5'd0, 32'h40, 32'd0, 32'd4, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
        push_expected(32'h40, 32'd4, 32'd0, 4'd0, 5'd10, 1'b1, 1'b1);
        tick();
        check_output("lw_x10");
        flush = 1'b1;
        apply_stimulus(1'b1, 32'h108, 5'd10, 5'd0, 32'h77, 32'd0, 32'd0, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7);
        check("flush.dec_ready", 32'(dec_ready), 32'd0);
        tick();
        check("flush.ex_valid",   32'(ex_valid),   32'd0);
        check("flush.ex_reg_wr",  32'(ex_reg_wr),  32'd0);
        check("flush.bubble_cnt", 32'(bubble_cnt), 32'd1);
        flush = 1'b0;
        #1;
        check("post_flush.dec_ready", 32'(dec_ready), 32'd1);
        push_expected(32'h77, 32'd0, 32'd0, 4'd7, 5'd11, 1'b1, 1'b0);
        tick();
        check_output("sub_after_flush");

        // Asynchronous reset mid-stream, then first capture after release
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        rst_n = 1'b1;
        apply_stimulus(1'b1, 32'h200, 5'd2, 5'd3, 32'h21, 32'h31, 32'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        check("post_reset.dec_ready", 32'(dec_ready), 32'd1);
        push_expected(32'h21, 32'h31, 32'h31, 4'd2, 5'd12, 1'b1, 1'b0);
        tick();
        check_output("xor_after_reset");

        // Idle decode produces a plain bubble without counting it
        apply_stimulus(1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        tick();
        check("idle.ex_valid",   32'(ex_valid),   32'd0);
        check("idle.bubble_cnt", 32'(bubble_cnt), 32'd0);

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline register for the RISC-V core, sitting directly upstream of the combinational ALU. It captures one decoded instruction per cycle and resolves operand forwarding from the EX, MEM and WB stages. It selects the final A/B operands and alu_op, and presents them as registered values to the ALU. It also detects load-use hazards, inserts bubbles, honours downstream back-pressure and flush, and counts inserted bubbles.

## Interface
- No parameters; data width 32, register address width 5.
- Reset is asynchronous, active-low; single clock.

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  stage accepts the instruction this cycle
- dec_pc  in  32  instruction PC
- dec_rs1_addr, dec_rs2_addr  in  5 each  source register indices
- dec_rs1_data, dec_rs2_data  in  32 each  register-file read data
- dec_imm  in  32  sign-extended immediate
- dec_rd_addr  in  5  destination register
- dec_reg_wr  in  1  instruction writes rd
- dec_is_load  in  1  instruction is a load
- dec_a_sel  in  1  0: A=rs1, 1: A=pc
- dec_b_sel  in  1  0: B=rs2, 1: B=imm
- dec_alu_op  in  4  ALU opcode: 0 add, 1 sll, 2 xor, 3 srl, 4 sra, 5 or, 6 and, 7 sub, 8 pass A, 9 pass B
- alu_a, alu_b  out  32 each  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_result  in  32  ALU output for the held instruction
- ex_valid  out  1  held instruction is valid
- ex_ready  in  1  downstream accepts held instruction
- ex_rd_addr  out  5  held rd
- ex_reg_wr  out  1  held write enable (0 on bubble)
- ex_is_load  out  1  held load flag
- ex_store_data  out  32  forwarded rs2 value, used for stores
- mem_reg_wr, mem_rd_addr, mem_data  in  1/5/32  MEM-stage writeback candidate
- wb_reg_wr, wb_rd_addr, wb_data  in  1/5/32  WB-stage writeback candidate
- flush  in  1  kill held instruction and refuse new one
- bubble_cnt  out  16  saturating count of inserted load-use bubbles

## Operation
- Reset values: all registered outputs are 0, including ex_valid, alu_a, alu_b, alu_op, ex_* and bubble_cnt.
- Advance condition: adv = ~ex_valid | ex_ready.
- Load-use hazard: lu = ex_valid & ex_is_load & dec_valid & ex_rd_addr≠0 & (ex_rd_addr==dec_rs1_addr | ex_rd_addr==dec_rs2_addr).
  - Both rs compares apply regardless of the sel bits.
- dec_ready = adv & ~lu & ~flush.
- Forwarding applies to each of rs1 and rs2, at capture. The first matching source wins:
  1. Held EX instruction when ex_valid & ex_reg_wr & ~ex_is_load & ex_rd_addr==rs: use alu_result.
  2. MEM when mem_reg_wr & mem_rd_addr==rs: use mem_data.
  3. WB when wb_reg_wr & wb_rd_addr==rs: use wb_data.
  4. Otherwise use dec_rsN_data.
  - rs==0 never forwards; the value is dec_rsN_data.
- Capture on dec_valid & dec_ready:
  - alu_a = dec_a_sel ? dec_pc : fwd_rs1.
  - alu_b = dec_b_sel ? dec_imm : fwd_rs2.
  - ex_store_data = fwd_rs2.
  - alu_op, ex_rd_addr, ex_reg_wr and ex_is_load copied from decode.
  - ex_valid = 1.
- Bubble when adv & ~(dec_valid & dec_ready): ex_valid=0 and ex_reg_wr=0; other payload registers hold.
- Hold when ~adv: all registers hold and dec_ready=0.
- flush has highest priority: next cycle ex_valid=0 and ex_reg_wr=0, no capture, and bubble_cnt is unchanged.
- bubble_cnt increments by 1 on every cycle where lu & adv & ~flush, and saturates at 0xFFFF.
- alu_op values 10–15 pass through unchanged; the ALU treats them as add.

## Timing
- Latency is 1 cycle: operands accepted at edge N appear on alu_a/alu_b/alu_op after edge N and stay stable until the next advance.
- Back-to-back dependent ALU ops run with zero stalls via EX forwarding.
- A load followed by a dependent instruction costs exactly 1 bubble; the dependent instruction then forwards from MEM.
- ex_valid only changes on edges where adv or flush holds.
- When rst_n asserts mid-operation, outputs clear immediately (asynchronous). The first capture is possible on the first edge after deassertion.

## Test plan
- Reset then accept of `addi x1,x0,5` (a_sel=0, b_sel=1, imm=5, op=0, rs1 data 0) -> next cycle alu_a=0, alu_b=5, alu_op=0, ex_valid=1, ex_rd_addr=1.
- Held `x1=5`, alu_result=5, then `add x2,x1,x1` with stale rs data 0 -> alu_a=5, alu_b=5; with MEM and WB also writing x1 (7, 9), EX still wins.
- Held load to x3, then `sub x4,x3,x0` -> dec_ready=0 for one cycle, ex_valid=0, bubble_cnt=1. The next cycle captures alu_a=mem_data (0x1234).
- Writes to x0 from EX/MEM/WB with rs1=0 and dec_rs1_data=0 -> alu_a=0.
- ex_ready=0 for 3 cycles while dec_valid=1 -> dec_ready=0 and outputs stable; the pending instruction is captured on the cycle ex_ready returns to 1.
- flush while holding a valid instruction with dec_valid=1 -> next cycle ex_valid=0, ex_reg_wr=0, dec_ready=0 during the flush cycle. Mid-stream rst_n=0 clears all outputs immediately.
